// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, line levels and the baud divisor helper.
// Used by the transmitter now and by the planned receiver later.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last cycle of each bit.
// Synchronous clear restarts the period so the first bit is full length.
module uart_baud_gen #(
  parameter int BAUD_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready intake and registered outputs.
// Optional parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int BAUD_DIV   = calc_baud_div(CLK_FREQ, BAUD_RATE),
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  output logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              dout
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || BAUD_DIV < 2) begin : g_cfg_err
    $error("uart_tx_param: illegal parameter combination");
  end

  uart_state_t      state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             dout_q, dout_d;
  logic             ready_q, busy_q;
  logic [DATA_W-1:0] shreg_q;
  logic             load, shift, tick;

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state_q == IDLE),
    .tick(tick)
  );

`ifdef UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (load) begin
      par_q <= (^data) ^ 1'(PARITY_ODD);
    end
  end
`endif

  // Control registers; ready/busy are registered from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      dout_q     <= LINE_IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      dout_q     <= dout_d;
      ready_q    <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
    end
  end

  // Payload shift register, LSB leaves first
  always_ff @(posedge clk) begin
    if (load) begin
      shreg_q <= data;
    end else if (shift) begin
      shreg_q <= {1'b0, shreg_q[DATA_W-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    dout_d     = dout_q;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state_q)
      IDLE: begin
        dout_d = LINE_IDLE;
        if (valid) begin
          state_d = START;
          dout_d  = LINE_START;
          load    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          dout_d    = shreg_q[0];
          shift     = 1'b1;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            dout_d    = par_q;
`else
            state_d   = STOP;
            dout_d    = LINE_IDLE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            dout_d    = shreg_q[0];
            shift     = 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          dout_d  = LINE_IDLE;
        end
      end
`endif
      STOP: begin
        dout_d = LINE_IDLE;
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d    = IDLE;
            stop_cnt_d = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = LINE_IDLE;
      end
    endcase
  end

  assign dout  = dout_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: an 8N1/even instance and an 8N2/odd instance
// at BAUD_DIV=10, checked cycle by cycle against a frame-level line model.
module tb_uart_tx_param;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BD        = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid1, valid2, ready1, ready2, busy1, busy2, dout1, dout2;
  logic [7:0] data1, data2;
  int checks = 0;
  int errors = 0;

  uart_tx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) u1 (
    .clk(clk), .rst(rst), .valid(valid1), .ready(ready1), .data(data1), .busy(busy1), .dout(dout1)
  );

  uart_tx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_W(8), .STOP_BITS(2), .PARITY_ODD(1)
  ) u2 (
    .clk(clk), .rst(rst), .valid(valid2), .ready(ready2), .data(data2), .busy(busy2), .dout(dout2)
  );

  // Line model: frame position idx -> expected line level
  function automatic logic exp_bit(input logic [7:0] d, input int idx, input bit odd);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (P == 1 && idx == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  function automatic logic dout_of(input int w);
    return (w == 2) ? dout2 : dout1;
  endfunction
  function automatic logic ready_of(input int w);
    return (w == 2) ? ready2 : ready1;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 2) ? busy2 : busy1;
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_valid(input int w, input logic v, input logic [7:0] d);
    if (w == 2) begin
      valid2 = v;
      data2  = d;
    end else begin
      valid1 = v;
      data1  = d;
    end
  endtask

  // Called at the falling edge right after acceptance; returns at the falling edge
  // after the frame's last bit, where the line must be idle again.
  task automatic check_frame(input string name, input int w, input logic [7:0] d,
                             input int pulse_at, output int low_cycles, output logic par_seen);
    int   stop_n = (w == 2) ? 2 : 1;
    bit   odd = (w == 2);
    int   nb = 1 + 8 + P + stop_n;
    int   len = nb * BD;
    logic midv[16];
    int   edge_bad = 0;
    int   ctrl_bad = 0;
    low_cycles = 0;
    par_seen   = 1'b0;
    for (int c = 0; c < len; c++) begin
      int   b = c / BD;
      logic dv = dout_of(w);
      if (dv !== exp_bit(d, b, odd)) edge_bad++;
      if (c % BD == BD / 2) midv[b] = dv;
      if (P == 1 && b == 9 && c % BD == BD / 2) par_seen = dv;
      if (ready_of(w) !== 1'b0 || busy_of(w) !== 1'b1) ctrl_bad++;
      if (ready_of(w) === 1'b0) low_cycles++;
      if (pulse_at >= 0 && c == pulse_at) set_valid(w, 1'b1, 8'h3C);
      else if (pulse_at >= 0 && c == pulse_at + 1) set_valid(w, 1'b0, 8'($urandom));
      @(negedge clk);
    end
    for (int b = 0; b < nb; b++)
      chk1($sformatf("%s bit%0d", name, b), midv[b], exp_bit(d, b, odd));
    chki($sformatf("%s cycles off-level", name), edge_bad, 0);
    chki($sformatf("%s ready/busy wrong cycles", name), ctrl_bad, 0);
    chk1($sformatf("%s ready at end", name), ready_of(w), 1'b1);
    chk1($sformatf("%s busy at end", name), busy_of(w), 1'b0);
    chk1($sformatf("%s dout at end", name), dout_of(w), 1'b1);
  endtask

  task automatic send_frame(input string name, input int w, input logic [7:0] d,
                            input int pulse_at, output int low_cycles, output logic par_seen);
    int n = 0;
    while (ready_of(w) !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk1($sformatf("%s ready before send", name), ready_of(w), 1'b1);
    set_valid(w, 1'b1, d);
    @(negedge clk);
    set_valid(w, 1'b0, 8'($urandom));
    check_frame(name, w, d, pulse_at, low_cycles, par_seen);
  endtask

  typedef struct {
    int         which;
    logic [7:0] data;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   low;
    logic par;
    int   idle_bad;

    tbl[0] = '{1, 8'hA5, 100 + 10 * P, 1'b0};
    tbl[1] = '{1, 8'h07, 100 + 10 * P, 1'b1};
    tbl[2] = '{2, 8'h07, 110 + 10 * P, 1'b0};
    tbl[3] = '{1, 8'h55, 100 + 10 * P, 1'b0};
    tbl[4] = '{2, 8'hFF, 110 + 10 * P, 1'b1};
    tbl[5] = '{2, 8'h3C, 110 + 10 * P, 1'b1};

    rst = 1'b0;
    set_valid(1, 1'b0, 8'h00);
    set_valid(2, 1'b0, 8'h00);

    // Reset held for 5 cycles, then released
    repeat (5) begin
      @(negedge clk);
      chk1("rst dout1", dout1, 1'b1);
      chk1("rst ready1", ready1, 1'b1);
      chk1("rst busy1", busy1, 1'b0);
      chk1("rst dout2", dout2, 1'b1);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("post-rst dout1", dout1, 1'b1);
      chk1("post-rst ready1", ready1, 1'b1);
      chk1("post-rst busy2", busy2, 1'b0);
    end

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      string nm = $sformatf("vec%0d", i);
      send_frame(nm, tbl[i].which, tbl[i].data, -1, low, par);
      chki({nm, " frame length"}, low, tbl[i].exp_len);
`ifdef UART_TX_PARITY_EN
      chk1({nm, " parity bit"}, par, tbl[i].exp_par);
`endif
    end

    // Back-to-back on the 2-stop instance with valid held high
    set_valid(2, 1'b1, 8'h00);
    @(negedge clk);
    data2 = 8'hFF;
    check_frame("b2b f1", 2, 8'h00, -1, low, par);
    chki("b2b f1 length", low, 110 + 10 * P);
    @(negedge clk);
    set_valid(2, 1'b0, 8'h00);
    check_frame("b2b f2", 2, 8'hFF, -1, low, par);
    chki("b2b f2 length", low, 110 + 10 * P);

    // valid pulse during data bit 3 must be ignored
    send_frame("busy-ignore", 1, 8'hA5, 42, low, par);
    idle_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (ready1 !== 1'b1 || dout1 !== 1'b1) idle_bad++;
    end
    chki("busy-ignore no 2nd frame", idle_bad, 0);

    // Reset in the middle of data bit 4
    set_valid(1, 1'b1, 8'hA5);
    @(negedge clk);
    set_valid(1, 1'b0, 8'h00);
    repeat (54) @(negedge clk);
    chk1("mid data bit4", dout1, exp_bit(8'hA5, 5, 1'b0));
    chk1("mid ready low", ready1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("mid-rst dout", dout1, 1'b1);
    chk1("mid-rst ready", ready1, 1'b1);
    chk1("mid-rst busy", busy1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("mid-rst idle dout", dout1, 1'b1);
    send_frame("after-rst 55", 1, 8'h55, -1, low, par);
    chki("after-rst length", low, 100 + 10 * P);

    // Reset and valid together: reset wins
    rst = 1'b0;
    set_valid(1, 1'b1, 8'hAA);
    @(negedge clk);
    chk1("rst+valid ready", ready1, 1'b1);
    chk1("rst+valid dout", dout1, 1'b1);
    rst = 1'b1;
    set_valid(1, 1'b0, 8'h00);
    @(negedge clk);
    chk1("rst+valid no frame ready", ready1, 1'b1);
    chk1("rst+valid no frame dout", dout1, 1'b1);
    chk1("rst+valid no frame busy", busy1, 1'b0);

    // Randomised frames on either instance with random gaps
    for (int i = 0; i < 16; i++) begin
      int         w = int'($urandom_range(1, 2));
      logic [7:0] d = 8'($urandom);
      int         gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      send_frame($sformatf("rnd%0d u%0d %02h", i, w, d), w, d, -1, low, par);
      chki($sformatf("rnd%0d length", i), low, (1 + 8 + P + w) * BD);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
